// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
// master (mem_stage): drives dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata;
//                     receives dmem_rdata and dmem_ack.
// slave  (memory)   : the mirror image.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns EX/MEM load/store requests into single data-memory
// transactions (IDLE -> BUSY -> DONE), formats load data and drives MEM/WB.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   *_in               : EX/MEM controls, address/ALU result, store data, rd
//   dmem               : data-memory bus (master side)
//   reg_write_out, mem_to_reg_out, read_data_out, alu_res_out, write_reg_out
//                      : toward MEM/WB
//   stall              : freezes PC, IF/ID, ID/EX, EX/MEM
//   misalign_err       : one-cycle flag, misaligned access rejected in IDLE
//   bus_err            : one-cycle flag in DONE after an access timed out
module mem_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [1:0]        size_in,
  input  logic              load_unsigned_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       write_data_in,
  input  logic [4:0]        write_reg_in,
  mem_stage_if.master       dmem,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [31:0]       read_data_out,
  output logic [31:0]       alu_res_out,
  output logic [4:0]        write_reg_out,
  output logic              stall,
  output logic              misalign_err,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        we_q, uns_q, timeout_q;
  logic [1:0]  size_q, ofs_q;

  logic        access, misaligned, start, ack_busy, expire;
  logic [3:0]  cnt_inc;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
    is_misaligned = (size == 2'b01 && ofs[0]) || (size[1] && ofs != 2'b00);
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   store_be = 4'b0001 << ofs;
      2'b01:   store_be = ofs[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Little-endian lane select; the extension bit is forced to 0 for unsigned loads.
  function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic [1:0] ofs,
                                           input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{ofs, 3'b000} +: 8];
    h = ofs[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   load_fmt = {{24{b[7] & ~uns}}, b};
      2'b01:   load_fmt = {{16{h[15] & ~uns}}, h};
      default: load_fmt = rd;
    endcase
  endfunction

  assign access     = mem_read_in | mem_write_in;
  assign misaligned = is_misaligned(size_in, alu_res_in[1:0]);
  assign start      = (state == IDLE) && access && !misaligned;
  assign ack_busy   = (state == BUSY) && dmem.dmem_ack;
  assign cnt_inc    = cnt + 4'd1;
  // The 15th BUSY cycle without ack is the last one; an ack in that cycle still wins.
  assign expire     = (state == BUSY) && !dmem.dmem_ack && (cnt_inc == 4'd15);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (ack_busy || expire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, timeout counter and load-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      ofs_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      addr_q    <= {alu_res_in[31:2], 2'b00};
      wdata_q   <= store_data(size_in, write_data_in);
      be_q      <= store_be(size_in, alu_res_in[1:0]);
      we_q      <= mem_write_in;
      uns_q     <= load_unsigned_in;
      size_q    <= size_in;
      ofs_q     <= alu_res_in[1:0];
      timeout_q <= 1'b0;
    end else if (ack_busy) begin
      rdata_q   <= load_fmt(size_q, ofs_q, uns_q, dmem.dmem_rdata);
    end else if (state == BUSY) begin
      cnt       <= cnt_inc;
      if (expire) begin
        timeout_q <= 1'b1;
        rdata_q   <= '0;
      end
    end
  end

  // Output logic
  always_comb begin
    stall         = 1'b0;
    reg_write_out = reg_write_in;
    read_data_out = '0;
    misalign_err  = 1'b0;
    bus_err       = 1'b0;
    dmem.dmem_req = 1'b0;
    dmem.dmem_we  = 1'b0;
    dmem.dmem_be  = '0;
    case (state)
      IDLE: begin
        if (access) begin
          reg_write_out = 1'b0;
          if (misaligned) misalign_err = 1'b1;
          else            stall        = 1'b1;
        end
      end
      BUSY: begin
        stall         = 1'b1;
        reg_write_out = 1'b0;
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = we_q;
        dmem.dmem_be  = be_q;
      end
      DONE: begin
        read_data_out = rdata_q;
        bus_err       = timeout_q;
        if (timeout_q) reg_write_out = 1'b0;
      end
      default: ;
    endcase
  end

  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign mem_to_reg_out  = mem_to_reg_in;
  assign alu_res_out     = alu_res_in;
  assign write_reg_out   = write_reg_in;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed and random loads/stores against a
// behavioural model, checked by a scoreboard monitor on the falling edge.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [1:0]  size_in;
  logic        load_unsigned_in;
  logic [31:0] alu_res_in, write_data_in;
  logic [4:0]  write_reg_in;
  logic        reg_write_out, mem_to_reg_out;
  logic [31:0] read_data_out, alu_res_out;
  logic [4:0]  write_reg_out;
  logic        stall, misalign_err, bus_err;

  mem_stage_if dmem_bus();

  mem_stage dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .size_in(size_in), .load_unsigned_in(load_unsigned_in),
    .alu_res_in(alu_res_in), .write_data_in(write_data_in),
    .write_reg_in(write_reg_in),
    .dmem(dmem_bus),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .read_data_out(read_data_out), .alu_res_out(alu_res_out),
    .write_reg_out(write_reg_out),
    .stall(stall), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  localparam int K_PASS = 0, K_MIS = 1, K_MEM = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rd;
    logic        berr;
    logic        rw;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        m2r;
    int          stall_cycles;
  } item_t;

  item_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int o;
    o = int'(a % 4);
    if (sz == 2'b01) return (o % 2) != 0;
    if (sz >= 2'b10) return o != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int o;
    o = int'(a % 4);
    if (sz == 2'b00) return 4'(1 << o);
    if (sz == 2'b01) return (o >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic uns, input logic [31:0] rdata);
    logic [31:0] v;
    int o;
    o = int'(a % 4);
    if (sz == 2'b00) begin
      v = (rdata >> (8 * o)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (rdata >> (16 * (o / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_pass(input logic [31:0] alu, input logic rw, input logic ack);
    item_t it;
    @(posedge clk); #1;
    reset            = 1'b0;
    mem_read_in      = 1'b0;
    mem_write_in     = 1'b0;
    reg_write_in     = rw;
    mem_to_reg_in    = 1'($urandom);
    size_in          = 2'($urandom);
    load_unsigned_in = 1'($urandom);
    alu_res_in       = alu;
    write_data_in    = $urandom;
    write_reg_in     = 5'($urandom);
    dmem_bus.dmem_ack   = ack;
    dmem_bus.dmem_rdata = $urandom;
    it = '{default: 0};
    it.kind = K_PASS; it.rw = rw; it.alu = alu; it.wreg = write_reg_in; it.m2r = mem_to_reg_in;
    q.push_back(it);
  endtask

  // delay = BUSY cycle on which ack is given (1 = immediate); 0 = never ack
  task automatic do_mem(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int delay,
                        input logic [31:0] rdata, input logic rw);
    item_t it;
    bit    tmo, done;
    @(posedge clk); #1;
    reset            = 1'b0;
    mem_read_in      = rd;
    mem_write_in     = wr;
    reg_write_in     = rw;
    mem_to_reg_in    = rd & ~wr;
    size_in          = sz;
    load_unsigned_in = uns;
    alu_res_in       = addr;
    write_data_in    = wd;
    write_reg_in     = 5'($urandom);
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = $urandom;
    it = '{default: 0};
    it.alu = addr; it.wreg = write_reg_in; it.m2r = mem_to_reg_in;
    if (model_misaligned(sz, addr)) begin
      it.kind = K_MIS;
      q.push_back(it);
      return;
    end
    tmo = (delay == 0);
    it.kind  = K_MEM;
    it.addr  = addr & 32'hFFFF_FFFC;
    it.be    = model_be(sz, addr);
    it.we    = wr;
    it.wdata = model_wdata(sz, wd);
    it.chk_rd = !wr && !tmo;
    it.rd    = model_load(sz, addr, uns, rdata);
    it.berr  = tmo;
    it.rw    = tmo ? 1'b0 : rw;
    it.stall_cycles = tmo ? 16 : delay + 1;
    q.push_back(it);
    done = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!dmem_bus.dmem_req) begin
        dmem_bus.dmem_ack = 1'b0;
        done = 1'b1;
        break;
      end
      if (n == delay) begin
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = rdata;
      end else begin
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = $urandom;
      end
    end
    check("access_completes", 32'(done), 32'd1);
  endtask

  task automatic reset_in_busy();
    item_t it;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    size_in = 2'b10; load_unsigned_in = 1'b0; alu_res_in = 32'h300; write_data_in = '0;
    write_reg_in = 5'd7;
    dmem_bus.dmem_ack = 1'b0;
    it = '{default: 0};
    it.kind = K_MEM; it.addr = 32'h300; it.be = 4'hF; it.we = 1'b0; it.wdata = 32'h0;
    q.push_back(it);
    @(posedge clk); #1;                 // first BUSY cycle
    @(posedge clk); #1; reset = 1'b1;   // second BUSY cycle
    do_pass(32'h55, 1'b1, 1'b1);        // late ack while reset has taken effect
    do_pass(32'h66, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    item_t it;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (stall) stall_cnt++;
      if (dmem_bus.dmem_req) begin
        check("busy_queue_depth", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
          check("busy_kind",  32'(q[0].kind), 32'(K_MEM));
          check("dmem_addr",  dmem_bus.dmem_addr,  q[0].addr);
          check("dmem_be",    32'(dmem_bus.dmem_be), 32'(q[0].be));
          check("dmem_we",    32'(dmem_bus.dmem_we), 32'(q[0].we));
          if (q[0].we) check("dmem_wdata", dmem_bus.dmem_wdata, q[0].wdata);
          check("busy_stall", 32'(stall), 32'd1);
          check("busy_reg_write", 32'(reg_write_out), 32'd0);
        end
      end else if (misalign_err) begin
        check("mis_queue_depth", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
          it = q.pop_front();
          check("mis_kind", 32'(it.kind), 32'(K_MIS));
          check("mis_stall", 32'(stall), 32'd0);
          check("mis_reg_write", 32'(reg_write_out), 32'd0);
        end
      end else if (prev_stall && !stall) begin
        check("done_queue_depth", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
          it = q.pop_front();
          check("done_kind", 32'(it.kind), 32'(K_MEM));
          check("stall_cycles", 32'(stall_cnt), 32'(it.stall_cycles));
          check("done_bus_err", 32'(bus_err), 32'(it.berr));
          check("done_reg_write", 32'(reg_write_out), 32'(it.rw));
          check("done_alu_res", alu_res_out, it.alu);
          if (it.chk_rd) check("done_read_data", read_data_out, it.rd);
        end
      end else if (!stall) begin
        check("pass_queue_depth", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
          it = q.pop_front();
          check("pass_kind", 32'(it.kind), 32'(K_PASS));
          check("pass_alu_res", alu_res_out, it.alu);
          check("pass_reg_write", 32'(reg_write_out), 32'(it.rw));
          check("pass_write_reg", 32'(write_reg_out), 32'(it.wreg));
          check("pass_mem_to_reg", 32'(mem_to_reg_out), 32'(it.m2r));
          check("pass_read_data", read_data_out, 32'd0);
          check("pass_idle_bus", {28'd0, dmem_bus.dmem_be, dmem_bus.dmem_we, bus_err, misalign_err,
                                  dmem_bus.dmem_req}, 32'd0);
        end
      end else begin
        check("accept_reg_write", 32'(reg_write_out), 32'd0);
        if (q.size() != 0) check("accept_kind", 32'(q[0].kind), 32'(K_MEM));
      end
      prev_stall = stall;
      if (!stall) stall_cnt = 0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, wd, rdat;
    logic [1:0]  sz;
    logic        wr, rd, uns, rw;
    int          r, dly;
    reset = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
    size_in = '0; load_unsigned_in = 1'b0; alu_res_in = '0; write_data_in = '0; write_reg_in = '0;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    @(posedge clk); @(posedge clk);

    do_pass(32'h1234, 1'b1, 1'b0);
    do_mem(1, 0, 2'b00, 0, 32'h103, 32'h0, 3, 32'h80FF_FFFF, 1);
    do_mem(1, 0, 2'b00, 1, 32'h103, 32'h0, 3, 32'h80FF_FFFF, 1);
    do_mem(0, 1, 2'b01, 0, 32'h202, 32'h0000_BEEF, 1, 32'h0, 0);
    do_mem(1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0, 1);
    do_mem(1, 0, 2'b01, 0, 32'h203, 32'h0, 1, 32'h0, 1);
    do_mem(1, 0, 2'b10, 0, 32'h400, 32'h0, 0, 32'h0, 1);
    do_mem(1, 0, 2'b10, 0, 32'h404, 32'h0, 15, 32'hCAFE_F00D, 1);
    do_mem(1, 1, 2'b00, 0, 32'h501, 32'h0000_00A5, 2, 32'h0, 0);
    do_mem(1, 0, 2'b01, 0, 32'h502, 32'h0, 2, 32'h8001_7FFF, 1);
    do_mem(1, 0, 2'b01, 1, 32'h500, 32'h0, 1, 32'h8001_9ABC, 1);
    reset_in_busy();

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        do_pass($urandom, 1'($urandom), 1'($urandom));
      end else begin
        wr   = (r >= 7);
        rd   = !wr || 1'($urandom);
        sz   = 2'($urandom);
        uns  = 1'($urandom);
        a    = $urandom;
        if (1'($urandom)) a = a & 32'hFFFF_FFFC;
        wd   = $urandom;
        rdat = $urandom;
        rw   = wr ? 1'b0 : 1'($urandom);
        dly  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 5));
        do_mem(rd, wr, sz, uns, a, wd, dly, rdat, rw);
      end
    end
    do_pass(32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
